// File: rtl/mem_initiator.sv
// mem_initiator: single-outstanding load/store initiator for the 512x32 negedge RAM.
// Drives registered Read/Write/Addr/Data strobes and returns one response beat
// over a valid/ready handshake.
// Optional build macro WRITE_VERIFY_EN: stores are read back one cycle after the
// write, and a mismatch is reported on resp_err.
module mem_initiator #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

`ifdef WRITE_VERIFY_EN
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_VERIFY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
`endif

  state_t            r_state, w_next;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              w_accept;

  // A new request may enter while idle, or on the very edge the pending
  // response is consumed (back-to-back).
  assign req_ready = (r_state == S_IDLE) | ((r_state == S_RESP) & resp_ready);
  assign w_accept  = req_valid & req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_ACCESS;
`ifdef WRITE_VERIFY_EN
      S_ACCESS: w_next = r_we ? S_VERIFY : S_RESP;
      S_VERIFY: w_next = S_RESP;
`else
      S_ACCESS: w_next = S_RESP;
`endif
      S_RESP:   if (resp_ready) w_next = req_valid ? S_ACCESS : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

`ifndef WRITE_VERIFY_EN
  assign resp_err = 1'b0;
`endif

  // Registered RAM strobes, request latches and response beat
  always_ff @(posedge clk) begin
    if (clr) begin
      r_we       <= 1'b0;
      r_wdata    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      ram_read   <= 1'b0;
      ram_write  <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
`ifdef WRITE_VERIFY_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_ACCESS: begin
          // RAM acted on the negedge inside this cycle; drop the strobe now.
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
`ifdef WRITE_VERIFY_EN
          if (r_we) begin
            ram_read <= 1'b1;           // read back the word just written
          end else begin
            resp_rdata <= ram_rdata;
            resp_valid <= 1'b1;
          end
`else
          resp_rdata <= r_we ? r_wdata : ram_rdata;
          resp_valid <= 1'b1;
`endif
        end
`ifdef WRITE_VERIFY_EN
        S_VERIFY: begin
          ram_read   <= 1'b0;
          resp_rdata <= r_wdata;
          resp_err   <= (ram_rdata != r_wdata);
          resp_valid <= 1'b1;
        end
`endif
        S_RESP:   if (resp_ready) resp_valid <= 1'b0;
        default:  ;
      endcase
      // Accept overrides: exactly one strobe raised for the new access.
      if (w_accept) begin
        r_we      <= req_we;
        r_wdata   <= req_wdata;
        ram_addr  <= req_addr;
        ram_wdata <= req_wdata;
        ram_write <= req_we;
        ram_read  <= ~req_we;
`ifdef WRITE_VERIFY_EN
        resp_err  <= 1'b0;
`endif
      end
    end
  end

endmodule
